// File: rtl/aidc_eop_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aidc_eop_gen_pkg
// Description : Shared constants, beat type and helpers for the AIDC framing
//               blocks (SOP-framed to LAST-framed conversion and siblings).
// Revision    : 1.0 - initial release
// ============================================================================
package aidc_eop_gen_pkg;

  // Default per-packet beat limit; 0 means unlimited.
  localparam int AIDC_MAX_BEATS = 16;

  // Default payload width used by the shared beat type.
  localparam int AIDC_DATA_W = 32;

  // One beat as seen by framing blocks that carry both delimiters.
  typedef struct packed {
    logic                   sop;
    logic                   last;
    logic [AIDC_DATA_W-1:0] data;
  } aidc_beat_t;

  // Width of a counter that must hold values 0..max_beats (never below 1).
  function automatic int aidc_cnt_w(input int max_beats);
    return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
  endfunction

endpackage : aidc_eop_gen_pkg
`default_nettype wire

// File: rtl/aidc_eop_gen.sv
`default_nettype none
// ============================================================================
// Module      : aidc_eop_gen
// Description : Converts an SOP-delimited beat stream into a LAST-delimited
//               stream. One beat is held in a lookahead register; it is
//               released when its successor is accepted (last = successor's
//               sop), when the idle flush input closes the packet, or when
//               the packet reaches MAX_BEATS beats.
// Revision    : 1.0 - initial release
// ============================================================================
module aidc_eop_gen
  import aidc_eop_gen_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = AIDC_MAX_BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream, SOP framed
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  // downstream, LAST framed
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  // framing error pulse
  output logic              sop_err_o
);

  localparam int CNT_W = aidc_cnt_w(MAX_BEATS);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // Lookahead register and framing state
  logic              hold_vld_q,   hold_vld_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;
  logic [CNT_W-1:0]  hold_cnt_q,   hold_cnt_d;
  logic              expect_sop_q, expect_sop_d;
  logic              sop_err_q,    sop_err_d;

  // Combinational helpers
  logic at_max;
  logic in_acc;
  logic out_fire;
  logic err;

  // Held beat has reached the packet limit and must close on its own.
  assign at_max = (MAX_BEATS != 0) && (hold_cnt_q == C_CNT_MAX);

  // Output view of the held beat; ready depends only on state and ready_i.
  always_comb begin
    ready_o   = !hold_vld_q || ready_i;
    valid_o   = hold_vld_q && (valid_i || flush_i || at_max);
    last_o    = at_max || (valid_i ? sop_i : flush_i);
    data_o    = hold_data_q;
    sop_err_o = sop_err_q;
  end

  assign in_acc   = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  // A non-sop beat is an error when it cannot continue an open packet:
  // either the held beat is closing at the limit, or nothing is open.
  assign err = in_acc && !sop_i && (hold_vld_q ? at_max : expect_sop_q);

  // Next-state logic for the hold register, beat counter and sop tracking.
  always_comb begin
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_cnt_d   = hold_cnt_q;
    expect_sop_d = expect_sop_q;
    sop_err_d    = err;

    if (in_acc) begin
      // New beat replaces the held one even if that one leaves this cycle;
      // an errored beat starts a fresh packet.
      hold_vld_d   = 1'b1;
      hold_data_d  = data_i;
      hold_cnt_d   = (sop_i || err) ? C_CNT_ONE : hold_cnt_q + C_CNT_ONE;
      expect_sop_d = 1'b0;
    end else if (out_fire) begin
      hold_vld_d = 1'b0;
      if (last_o) begin
        expect_sop_d = 1'b1;
      end
    end
  end

  // State register; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_cnt_q   <= '0;
      expect_sop_q <= 1'b1;
      sop_err_q    <= 1'b0;
    end else begin
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      hold_cnt_q   <= hold_cnt_d;
      expect_sop_q <= expect_sop_d;
      sop_err_q    <= sop_err_d;
    end
  end

endmodule : aidc_eop_gen
`default_nettype wire
